psg_bus_ctrl: RTL and testbench
===============================

Name: psg_bus_ctrl

Overview:
- Sequences one to three PSG cores (TurboSound-style) from the Z80 I/O bus.
- Decodes Spectrum 128 PSG port accesses, keeps the active-chip select, and turns each CPU access into correctly timed per-chip bdir/bc1 strobes.
- Returns register read data to the CPU bus.
- Sits between the CPU I/O decode and the PSG instances; its psg_sel output goes to the audio mixer.

Parameters:
NUM_CHIPS, 2, number of PSG instances driven (1..3)
SEL_BASE, 8'hFC, lowest value written to the register port that is treated as a chip-select command rather than an address

Ports:
clock  in  1  system clock; all PSGs share it
reset  in  1  asynchronous, active-low reset
ay_enable  in  1  PSG port decode enable; 0 = block ignores the bus
iorq_n  in  1  Z80 IORQ, asynchronous to clock
rd_n  in  1  Z80 RD
wr_n  in  1  Z80 WR
m1_n  in  1  Z80 M1 (interrupt acknowledge filter)
addr  in  16  Z80 address bus
cpu_di  in  8  CPU data out (write data)
cpu_do  out  8  read data to CPU
cpu_oe  out  1  cpu_do valid; drive the bus
psg_bdir  out  NUM_CHIPS  per-chip BDIR
psg_bc1  out  NUM_CHIPS  per-chip BC1
psg_wdata  out  8  data to all PSG di inputs
psg_rdata  in  8*NUM_CHIPS  PSG do outputs, chip 0 in bits [7:0]
psg_sel  out  2  currently selected chip

Behaviour:
- Reset (async, reset=0): all bdir/bc1=0, psg_wdata=0, cpu_do=FF, cpu_oe=0, psg_sel=0, FSM=IDLE, sync flops inactive. Reset mid-access drops strobes immediately. After reset release, the access in progress is ignored until iorq_n deasserts.
- Port decode (partial, Spectrum 128):
  - REG port FFFD: addr[15]=1, addr[14]=1, addr[1]=0.
  - DATA port BFFD: addr[15]=1, addr[14]=0, addr[1]=0.
  - An access is valid only when ay_enable=1 and m1_n=1.
- Sync:
  - iorq_n, rd_n, wr_n each pass through 2 flops.
  - An access starts when synced iorq is active with exactly one of synced rd/wr active, and the previous synced iorq was inactive.
  - addr and cpu_di are sampled on the detection edge; they are stable by then.
- FSM states: IDLE, LATCH, WRITE, READ, WAIT_END.
  - IDLE -> LATCH: write to FFFD whose data is not a select command. psg_wdata=cpu_di.
  - IDLE -> WRITE: write to BFFD. psg_wdata=cpu_di.
  - IDLE -> READ: read of FFFD.
  - IDLE -> WAIT_END: any other decoded or undecoded access, or rd and wr both active. No strobe is produced.
  - LATCH: {bdir,bc1}=11 on the selected chip only, for exactly 1 clock, then WAIT_END.
  - WRITE: {bdir,bc1}=10 on the selected chip only, for exactly 1 clock, then WAIT_END.
  - READ: {bdir,bc1}=01 on the selected chip, held while synced rd/iorq stay active. Each clock, cpu_do <= selected psg_rdata slice and cpu_oe=1. On deassert: strobes 00, cpu_oe=0, cpu_do=FF, -> IDLE.
  - WAIT_END -> IDLE when synced iorq is inactive. This gives one strobe per CPU access however long IORQ is held.
- Latency: both iorq_n and wr_n are low at clock edge E0. Detection is at E2. The strobe is registered high E2->E3. cpu_oe first valid after E3 for reads.
- Chip select:
  - A write to FFFD with data >= SEL_BASE and (8'hFF - data) < NUM_CHIPS sets psg_sel = 8'hFF - data. No LATCH state is entered.
  - Any other data is forwarded as a normal register address latch.
  - With NUM_CHIPS=1, only FF is a select command; psg_sel stays 0.
  - The selected chip's address is untouched. Each chip keeps its own latched address.
- Non-selected chips always see {bdir,bc1}=00.
- A BFFD read is not decoded: cpu_oe stays 0.
- ay_enable falling during an access: the current state completes normally. No new access is accepted.

Decomposition:
- Shared package psg_pkg holds:
  - the port decode masks/values (REG, DATA);
  - the FSM state encoding;
  - the {bdir,bc1} code constants (INACTIVE=00, READ=01, WRITE=10, LATCH=11);
  - SEL_BASE.
- One sub-module, z80_io_sync: 2-flop synchronisers for iorq_n/rd_n/wr_n plus the access-start edge detect. It uses the same async active-low reset.

Test Plan:
- Reset, then write 8'h07 to FFFD -> chip 0 only sees bc1/bdir=11 for 1 clock at E2-E3, with psg_wdata=07; chip 1 stays 00.
- Write FE to FFFD, then 8'h38 to BFFD -> psg_sel=1, no latch strobe, and chip 1 sees 10 for 1 clock with psg_wdata=38.
- Select chip 0, latch reg 7, write 3F, then read FFFD with rd held 6 clocks -> cpu_do=3F with cpu_oe=1 while READ is held; after rd rises, cpu_oe=0 and cpu_do=FF.
- IORQ held 20 clocks on a BFFD write -> exactly one 10 strobe.
- Interrupt acknowledge (m1_n=0, iorq_n=0) with addr=FFFD -> no strobe.
- Assert reset during READ state -> strobes, cpu_oe and psg_sel drop in the same cycle.
- NUM_CHIPS=2: write FD to FFFD -> treated as an address latch on the current chip; psg_sel unchanged.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared constants for the PSG bus controller: port decode, FSM states, strobe codes.
package psg_pkg;

  // Partial Spectrum 128 decode: addr[15], addr[14], addr[1]
  localparam logic [15:0] PORT_MASK = 16'hC002;
  localparam logic [15:0] PORT_REG  = 16'hC000;  // FFFD
  localparam logic [15:0] PORT_DATA = 16'h8000;  // BFFD

  // Lowest register-port value treated as a chip-select command
  localparam logic [7:0] PSG_SEL_BASE = 8'hFC;

  // {bdir,bc1} bus-control codes
  localparam logic [1:0] BC_INACTIVE = 2'b00;
  localparam logic [1:0] BC_READ     = 2'b01;
  localparam logic [1:0] BC_WRITE    = 2'b10;
  localparam logic [1:0] BC_LATCH    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_READ     = 3'd3,
    ST_WAIT_END = 3'd4
  } psg_state_e;

  // True when the address matches the given port under the partial decode
  function automatic logic port_hit(input logic [15:0] a, input logic [15:0] port);
    return (a & PORT_MASK) == port;
  endfunction

endpackage

// File: rtl/z80_io_sync.sv
// Two-flop synchronisers for the Z80 I/O strobes plus access-start edge detect.
module z80_io_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_iorq_n,
  input  logic i_rd_n,
  input  logic i_wr_n,
  output logic o_iorq,
  output logic o_rd,
  output logic o_wr,
  output logic o_start_c
);

  logic [1:0] r_iorq_sr;
  logic [1:0] r_rd_sr;
  logic [1:0] r_wr_sr;
  logic       r_iorq_prev;
  logic [1:0] r_warm;
  logic       r_armed;

  // Synchronise active-high copies; arm only after seeing IORQ idle once the
  // pipeline holds real samples, so an access spanning reset release is ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_iorq_sr   <= 2'b00;
      r_rd_sr     <= 2'b00;
      r_wr_sr     <= 2'b00;
      r_iorq_prev <= 1'b0;
      r_warm      <= 2'b00;
      r_armed     <= 1'b0;
    end else begin
      r_iorq_sr   <= {r_iorq_sr[0], ~i_iorq_n};
      r_rd_sr     <= {r_rd_sr[0], ~i_rd_n};
      r_wr_sr     <= {r_wr_sr[0], ~i_wr_n};
      r_iorq_prev <= r_iorq_sr[1];
      r_warm      <= {r_warm[0], 1'b1};
      if (r_warm[1] && !r_iorq_sr[1]) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_iorq = r_iorq_sr[1];
  assign o_rd   = r_rd_sr[1];
  assign o_wr   = r_wr_sr[1];
  // Rising IORQ with a read or write qualifier; rd+wr together is classified downstream
  assign o_start_c = r_armed & r_iorq_sr[1] & ~r_iorq_prev & (r_rd_sr[1] | r_wr_sr[1]);

endmodule

// File: rtl/psg_bus_ctrl.sv
// Z80 I/O to multi-PSG sequencer: port decode, chip select, bdir/bc1 strobes, read-back.
module psg_bus_ctrl #(
  parameter int unsigned NUM_CHIPS = 2,
  parameter logic [7:0]  SEL_BASE  = psg_pkg::PSG_SEL_BASE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ay_enable,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   m1_n,
  input  logic [15:0]            addr,
  input  logic [7:0]             cpu_di,
  output logic [7:0]             cpu_do,
  output logic                   cpu_oe,
  output logic [NUM_CHIPS-1:0]   psg_bdir,
  output logic [NUM_CHIPS-1:0]   psg_bc1,
  output logic [7:0]             psg_wdata,
  input  logic [8*NUM_CHIPS-1:0] psg_rdata,
  output logic [1:0]             psg_sel
);

  import psg_pkg::*;

  logic w_iorq, w_rd, w_wr, w_start;
  logic w_valid, w_is_reg, w_is_data, w_wr_only, w_rd_only, w_is_sel;
  logic [1:0]           w_sel_val;
  logic [NUM_CHIPS-1:0] w_sel_mask;
  logic [7:0]           w_rdata_sel;

  psg_state_e           r_state;
  logic [NUM_CHIPS-1:0] r_bdir;
  logic [NUM_CHIPS-1:0] r_bc1;
  logic [7:0]           r_wdata;
  logic [7:0]           r_cpu_do;
  logic                 r_cpu_oe;
  logic [1:0]           r_sel;

  z80_io_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .i_iorq_n  (iorq_n),
    .i_rd_n    (rd_n),
    .i_wr_n    (wr_n),
    .o_iorq    (w_iorq),
    .o_rd      (w_rd),
    .o_wr      (w_wr),
    .o_start_c (w_start)
  );

  // Expand a {bdir,bc1} code onto the selected chip only
  function automatic logic [2*NUM_CHIPS-1:0] strobe(input logic [1:0] code,
                                                    input logic [NUM_CHIPS-1:0] mask);
    logic [NUM_CHIPS-1:0] b, c;
    b = code[1] ? mask : '0;
    c = code[0] ? mask : '0;
    return {b, c};
  endfunction

  assign w_valid    = ay_enable & m1_n;
  assign w_is_reg   = port_hit(addr, PORT_REG);
  assign w_is_data  = port_hit(addr, PORT_DATA);
  assign w_wr_only  = w_wr & ~w_rd;
  assign w_rd_only  = w_rd & ~w_wr;
  assign w_is_sel   = (cpu_di >= SEL_BASE) && ((8'hFF - cpu_di) < 8'(NUM_CHIPS));
  assign w_sel_val  = 2'(8'hFF - cpu_di);
  assign w_sel_mask = NUM_CHIPS'(1) << r_sel;

  // Mux the selected chip's read data; 0xFF if selection is out of range
  always_comb begin
    w_rdata_sel = 8'hFF;
    for (int i = 0; i < int'(NUM_CHIPS); i++) begin
      if (r_sel == 2'(i)) begin
        w_rdata_sel = psg_rdata[i*8 +: 8];
      end
    end
  end

  // Access sequencer: one strobe per detected CPU access, read held while RD/IORQ stay low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_bdir   <= '0;
      r_bc1    <= '0;
      r_wdata  <= 8'h00;
      r_cpu_do <= 8'hFF;
      r_cpu_oe <= 1'b0;
      r_sel    <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (w_valid && w_wr_only && w_is_reg && w_is_sel) begin
              r_sel   <= w_sel_val;
              r_state <= ST_WAIT_END;
            end else if (w_valid && w_wr_only && w_is_reg) begin
              r_wdata          <= cpu_di;
              {r_bdir, r_bc1}  <= strobe(BC_LATCH, w_sel_mask);
              r_state          <= ST_LATCH;
            end else if (w_valid && w_wr_only && w_is_data) begin
              r_wdata          <= cpu_di;
              {r_bdir, r_bc1}  <= strobe(BC_WRITE, w_sel_mask);
              r_state          <= ST_WRITE;
            end else if (w_valid && w_rd_only && w_is_reg) begin
              {r_bdir, r_bc1}  <= strobe(BC_READ, w_sel_mask);
              r_state          <= ST_READ;
            end else begin
              r_state <= ST_WAIT_END;
            end
          end
        end
        ST_LATCH, ST_WRITE: begin
          {r_bdir, r_bc1} <= strobe(BC_INACTIVE, w_sel_mask);
          r_state         <= ST_WAIT_END;
        end
        ST_READ: begin
          if (w_rd && w_iorq) begin
            r_cpu_do <= w_rdata_sel;
            r_cpu_oe <= 1'b1;
          end else begin
            {r_bdir, r_bc1} <= strobe(BC_INACTIVE, w_sel_mask);
            r_cpu_do        <= 8'hFF;
            r_cpu_oe        <= 1'b0;
            r_state         <= ST_IDLE;
          end
        end
        ST_WAIT_END: begin
          if (!w_iorq) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign psg_bdir  = r_bdir;
  assign psg_bc1   = r_bc1;
  assign psg_wdata = r_wdata;
  assign cpu_do    = r_cpu_do;
  assign cpu_oe    = r_cpu_oe;
  assign psg_sel   = r_sel;

endmodule

// File: tb/tb_psg_bus_ctrl.sv
// Directed bench for psg_bus_ctrl with two chips and a small behavioural PSG register model.
module tb_psg_bus_ctrl;

  localparam int unsigned NC = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              ay_enable;
  logic              iorq_n, rd_n, wr_n, m1_n;
  logic [15:0]       addr;
  logic [7:0]        cpu_di;
  logic [7:0]        cpu_do;
  logic              cpu_oe;
  logic [NC-1:0]     psg_bdir, psg_bc1;
  logic [7:0]        psg_wdata;
  logic [8*NC-1:0]   psg_rdata;
  logic [1:0]        psg_sel;

  int n_checks = 0;
  int n_errors = 0;

  int cnt_latch [NC];
  int cnt_write [NC];
  int cnt_oe;

  logic [3:0] m_addr [NC];
  logic [7:0] m_regs [NC][16];

  always #5 clock = ~clock;

  psg_bus_ctrl #(.NUM_CHIPS(NC), .SEL_BASE(8'hFC)) dut (
    .clock     (clock),
    .reset     (reset),
    .ay_enable (ay_enable),
    .iorq_n    (iorq_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .m1_n      (m1_n),
    .addr      (addr),
    .cpu_di    (cpu_di),
    .cpu_do    (cpu_do),
    .cpu_oe    (cpu_oe),
    .psg_bdir  (psg_bdir),
    .psg_bc1   (psg_bc1),
    .psg_wdata (psg_wdata),
    .psg_rdata (psg_rdata),
    .psg_sel   (psg_sel)
  );

  // PSG behaviour: latch address on 11, write register on 10, read data always presented
  always @(posedge clock) begin
    for (int i = 0; i < int'(NC); i++) begin
      if (psg_bdir[i] && psg_bc1[i]) begin
        m_addr[i] = psg_wdata[3:0];
        cnt_latch[i]++;
      end else if (psg_bdir[i] && !psg_bc1[i]) begin
        m_regs[i][m_addr[i]] = psg_wdata;
        cnt_write[i]++;
      end
    end
    if (cpu_oe) cnt_oe++;
  end

  always_comb begin
    for (int i = 0; i < int'(NC); i++) begin
      psg_rdata[i*8 +: 8] = m_regs[i][m_addr[i]];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic io_cycle(input logic [15:0] a, input logic [7:0] d, input logic is_wr,
                          input logic m1, input int hold);
    addr   = a;
    cpu_di = d;
    m1_n   = m1;
    iorq_n = 1'b0;
    if (is_wr) wr_n = 1'b0;
    else       rd_n = 1'b0;
    repeat (hold) tick();
    iorq_n = 1'b1;
    wr_n   = 1'b1;
    rd_n   = 1'b1;
    m1_n   = 1'b1;
    repeat (4) tick();
  endtask

  int l0, l1, w0, w1, oe0;

  task automatic snap();
    l0  = cnt_latch[0];
    l1  = cnt_latch[1];
    w0  = cnt_write[0];
    w1  = cnt_write[1];
    oe0 = cnt_oe;
  endtask

  initial begin
    for (int i = 0; i < int'(NC); i++) begin
      cnt_latch[i] = 0;
      cnt_write[i] = 0;
      m_addr[i]    = 4'd0;
      for (int r = 0; r < 16; r++) m_regs[i][r] = 8'h00;
    end
    cnt_oe    = 0;
    reset     = 1'b0;
    ay_enable = 1'b1;
    iorq_n    = 1'b1;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    m1_n      = 1'b1;
    addr      = 16'h0000;
    cpu_di    = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_bdir",  16'(psg_bdir),  16'h0);
    chk("rst_bc1",   16'(psg_bc1),   16'h0);
    chk("rst_wdata", 16'(psg_wdata), 16'h00);
    chk("rst_cpu_do",16'(cpu_do),    16'hFF);
    chk("rst_cpu_oe",16'(cpu_oe),    16'h0);
    chk("rst_sel",   16'(psg_sel),   16'h0);
    reset = 1'b1;
    repeat (3) tick();

    // Latch 07 on FFFD: strobe exactly E2..E3 on chip 0 only
    addr = 16'hFFFD; cpu_di = 8'h07; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    chk("lat_e0", 16'({psg_bdir, psg_bc1}), 16'h0);
    tick();
    chk("lat_e1", 16'({psg_bdir, psg_bc1}), 16'h0);
    tick();
    chk("lat_e2", 16'({psg_bdir, psg_bc1}), 16'b0101);
    chk("lat_wdata", 16'(psg_wdata), 16'h07);
    tick();
    chk("lat_e3", 16'({psg_bdir, psg_bc1}), 16'h0);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (4) tick();

    // Select chip 1 with FE, then data write 38 lands on chip 1 only
    snap();
    io_cycle(16'hFFFD, 8'hFE, 1'b1, 1'b1, 4);
    chk("selfe_sel", 16'(psg_sel), 16'h1);
    chk("selfe_nolatch", 16'((cnt_latch[0] - l0) + (cnt_latch[1] - l1)), 16'h0);
    io_cycle(16'hBFFD, 8'h38, 1'b1, 1'b1, 4);
    chk("wr38_chip1", 16'(cnt_write[1] - w1), 16'h1);
    chk("wr38_chip0", 16'(cnt_write[0] - w0), 16'h0);
    chk("wr38_wdata", 16'(psg_wdata), 16'h38);

    // Select chip 0, latch reg 7, write 3F, read back with RD held 6 clocks
    io_cycle(16'hFFFD, 8'hFF, 1'b1, 1'b1, 4);
    chk("selff_sel", 16'(psg_sel), 16'h0);
    snap();
    io_cycle(16'hFFFD, 8'h07, 1'b1, 1'b1, 4);
    io_cycle(16'hBFFD, 8'h3F, 1'b1, 1'b1, 4);
    chk("l7_latch0", 16'(cnt_latch[0] - l0), 16'h1);
    chk("w3f_write0", 16'(cnt_write[0] - w0), 16'h1);
    addr = 16'hFFFD; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (3) tick();
    chk("rd_e2_strobe", 16'({psg_bdir, psg_bc1}), 16'b0001);
    chk("rd_e2_oe", 16'(cpu_oe), 16'h0);
    tick();
    chk("rd_e3_oe", 16'(cpu_oe), 16'h1);
    chk("rd_e3_do", 16'(cpu_do), 16'h3F);
    repeat (2) tick();
    chk("rd_hold_oe", 16'(cpu_oe), 16'h1);
    chk("rd_hold_do", 16'(cpu_do), 16'h3F);
    chk("rd_hold_strobe", 16'({psg_bdir, psg_bc1}), 16'b0001);
    iorq_n = 1'b1; rd_n = 1'b1;
    repeat (3) tick();
    chk("rd_end_oe", 16'(cpu_oe), 16'h0);
    chk("rd_end_do", 16'(cpu_do), 16'hFF);
    chk("rd_end_strobe", 16'({psg_bdir, psg_bc1}), 16'h0);
    repeat (2) tick();

    // Long IORQ on a data write: exactly one write strobe
    snap();
    io_cycle(16'hBFFD, 8'h55, 1'b1, 1'b1, 20);
    chk("long_wr_once", 16'(cnt_write[0] - w0), 16'h1);

    // M1 low filters the access; ay_enable low ignores the bus
    snap();
    io_cycle(16'hFFFD, 8'h02, 1'b1, 1'b0, 4);
    chk("m1_nolatch", 16'(cnt_latch[0] - l0), 16'h0);
    ay_enable = 1'b0;
    io_cycle(16'hFFFD, 8'h03, 1'b1, 1'b1, 4);
    chk("dis_nolatch", 16'(cnt_latch[0] - l0), 16'h0);
    ay_enable = 1'b1;

    // BFFD read is not decoded
    snap();
    io_cycle(16'hBFFD, 8'h00, 1'b0, 1'b1, 6);
    chk("bffd_rd_oe", 16'(cnt_oe - oe0), 16'h0);

    // FD is not a select command with two chips: latch on current chip
    io_cycle(16'hFFFD, 8'hFE, 1'b1, 1'b1, 4);
    snap();
    io_cycle(16'hFFFD, 8'hFD, 1'b1, 1'b1, 4);
    chk("fd_sel", 16'(psg_sel), 16'h1);
    chk("fd_latch1", 16'(cnt_latch[1] - l1), 16'h1);
    chk("fd_latch0", 16'(cnt_latch[0] - l0), 16'h0);
    chk("fd_wdata", 16'(psg_wdata), 16'hFD);
    io_cycle(16'hBFFD, 8'hA5, 1'b1, 1'b1, 4);

    // Reset asserted during a chip-1 read drops everything immediately
    addr = 16'hFFFD; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (5) tick();
    chk("rr_oe", 16'(cpu_oe), 16'h1);
    chk("rr_do", 16'(cpu_do), 16'hA5);
    chk("rr_strobe", 16'({psg_bdir, psg_bc1}), 16'b0010);
    reset = 1'b0;
    #1;
    chk("rr_rst_strobe", 16'({psg_bdir, psg_bc1}), 16'h0);
    chk("rr_rst_oe", 16'(cpu_oe), 16'h0);
    chk("rr_rst_sel", 16'(psg_sel), 16'h0);
    chk("rr_rst_do", 16'(cpu_do), 16'hFF);
    #1;
    reset = 1'b1;
    snap();
    repeat (6) tick();
    chk("post_rst_strobe", 16'({psg_bdir, psg_bc1}), 16'h0);
    chk("post_rst_oe", 16'(cnt_oe - oe0), 16'h0);
    iorq_n = 1'b1; rd_n = 1'b1;
    repeat (4) tick();

    // Fresh access after the ignored one is accepted
    snap();
    io_cycle(16'hFFFD, 8'h01, 1'b1, 1'b1, 4);
    chk("after_latch0", 16'(cnt_latch[0] - l0), 16'h1);
    chk("after_latch1", 16'(cnt_latch[1] - l1), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
